// File: rtl/tlb_multiport.sv
// Fully associative Sv32 TLB: NUM_RQ registered lookup ports, 4 KiB/4 MiB pages,
// invalid-first then round-robin replacement, one outstanding page-walk request.
module tlb_multiport #(
    parameter int NUM_RQ = 2,
    parameter int LEN    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IN_clear,
    input  logic [NUM_RQ-1:0]       IN_rqValid,
    input  logic [NUM_RQ-1:0][19:0] IN_rqVpn,
    output logic [NUM_RQ-1:0]       OUT_resHit,
    output logic [NUM_RQ-1:0]       OUT_resFault,
    output logic [NUM_RQ-1:0][19:0] OUT_resPpn,
    output logic [NUM_RQ-1:0][2:0]  OUT_resRwx,
    output logic                    OUT_pwReqValid,
    output logic [19:0]             OUT_pwReqVpn,
    input  logic                    IN_pwReady,
    input  logic                    IN_pwResValid,
    input  logic [19:0]             IN_pwResVpn,
    input  logic [21:0]             IN_pwResPpn,
    input  logic                    IN_pwResSuper,
    input  logic                    IN_pwResFault,
    input  logic [2:0]              IN_pwResRwx
);

    localparam int IDX_W = $clog2(LEN);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [19:0]             req_vpn_q, req_vpn_d;
    logic                    drop_q, drop_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [LEN-1:0]          valid_q, valid_d;

    logic [19:0]             vpn_q [LEN];
    logic [19:0]             ppn_q [LEN];
    logic [2:0]              rwx_q [LEN];
    logic [LEN-1:0]          super_q;
    logic [LEN-1:0]          fault_q;

    logic [NUM_RQ-1:0]       hit_q, hit_d;
    logic [NUM_RQ-1:0]       flt_q, flt_d;
    logic [NUM_RQ-1:0][19:0] ppn_res_q, ppn_res_d;
    logic [NUM_RQ-1:0][2:0]  rwx_res_q, rwx_res_d;

    logic [NUM_RQ-1:0][LEN-1:0] rq_match;
    logic [LEN-1:0]          ins_match;
    logic [NUM_RQ-1:0]       rq_ins_match;
    logic [NUM_RQ-1:0]       miss;
    logic [NUM_RQ-1:0]       miss_sup;

    logic                    lk_found;
    logic [IDX_W-1:0]        lk_sel;
    logic                    ins_hit, free_found, evict, ins_en;
    logic [IDX_W-1:0]        ins_hit_idx, free_idx, ins_idx;
    logic                    cand_valid;
    logic [19:0]             cand_vpn;
    logic                    unused_ppn_hi;

    assign unused_ppn_hi = ^IN_pwResPpn[21:20];

    genvar gi, gj;
    generate
        for (gi = 0; gi < LEN; gi++) begin : g_entry
            assign ins_match[gi] = valid_q[gi] &&
                (super_q[gi] ? (vpn_q[gi][19:10] == IN_pwResVpn[19:10])
                             : (vpn_q[gi] == IN_pwResVpn));
            for (gj = 0; gj < NUM_RQ; gj++) begin : g_port
                assign rq_match[gj][gi] = valid_q[gi] &&
                    (super_q[gi] ? (vpn_q[gi][19:10] == IN_rqVpn[gj][19:10])
                                 : (vpn_q[gi] == IN_rqVpn[gj]));
            end
        end
        // A miss is not worth a walk if the walker is already on it or its result lands now.
        for (gj = 0; gj < NUM_RQ; gj++) begin : g_sup
            assign rq_ins_match[gj] = IN_pwResSuper ? (IN_rqVpn[gj][19:10] == IN_pwResVpn[19:10])
                                                    : (IN_rqVpn[gj] == IN_pwResVpn);
            assign miss_sup[gj] = (ins_en && rq_ins_match[gj]) ||
                                  ((state_q != S_IDLE) && (IN_rqVpn[gj] == req_vpn_q));
        end
    endgenerate

    always_comb begin
        hit_d     = '0;
        flt_d     = '0;
        ppn_res_d = '0;
        rwx_res_d = '0;
        miss      = '0;
        lk_found  = 1'b0;
        lk_sel    = '0;
        for (int p = 0; p < NUM_RQ; p++) begin
            lk_found = 1'b0;
            lk_sel   = '0;
            for (int e = LEN - 1; e >= 0; e--) begin
                if (rq_match[p][e]) begin
                    lk_found = 1'b1;
                    lk_sel   = IDX_W'(e);
                end
            end
            if (IN_rqValid[p] && !IN_clear) begin
                if (lk_found) begin
                    hit_d[p] = 1'b1;
                    if (fault_q[lk_sel]) begin
                        flt_d[p] = 1'b1;
                    end else begin
                        ppn_res_d[p] = super_q[lk_sel] ? {ppn_q[lk_sel][19:10], IN_rqVpn[p][9:0]}
                                                       : ppn_q[lk_sel];
                        rwx_res_d[p] = rwx_q[lk_sel];
                    end
                end else begin
                    miss[p] = 1'b1;
                end
            end
        end
    end

    // Stale walk results after a flush are discarded until a fresh request goes out.
    always_comb begin
        ins_hit     = 1'b0;
        ins_hit_idx = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int e = LEN - 1; e >= 0; e--) begin
            if (ins_match[e]) begin
                ins_hit     = 1'b1;
                ins_hit_idx = IDX_W'(e);
            end
            if (!valid_q[e]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(e);
            end
        end
        ins_en  = IN_pwResValid && !IN_clear && !(drop_q && (state_q == S_IDLE));
        evict   = !ins_hit && !free_found;
        ins_idx = ins_hit ? ins_hit_idx : (free_found ? free_idx : rr_q);
        valid_d = valid_q;
        rr_d    = rr_q;
        if (IN_clear) begin
            valid_d = '0;
        end else if (ins_en) begin
            valid_d[ins_idx] = 1'b1;
            if (evict) begin
                rr_d = rr_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        cand_valid = 1'b0;
        cand_vpn   = '0;
        for (int p = NUM_RQ - 1; p >= 0; p--) begin
            if (miss[p] && !miss_sup[p]) begin
                cand_valid = 1'b1;
                cand_vpn   = IN_rqVpn[p];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_vpn_d = req_vpn_q;
        drop_d    = drop_q;
        case (state_q)
            S_IDLE: begin
                if (cand_valid) begin
                    state_d   = S_REQ;
                    req_vpn_d = cand_vpn;
                    drop_d    = 1'b0;
                end
            end
            S_REQ: begin
                if (IN_pwReady) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (IN_pwResValid && (IN_pwResVpn == req_vpn_q)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (IN_clear) begin
            state_d = S_IDLE;
            drop_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            req_vpn_q <= '0;
            drop_q    <= 1'b0;
            rr_q      <= '0;
            valid_q   <= '0;
            hit_q     <= '0;
            flt_q     <= '0;
            ppn_res_q <= '0;
            rwx_res_q <= '0;
        end else begin
            state_q   <= state_d;
            req_vpn_q <= req_vpn_d;
            drop_q    <= drop_d;
            rr_q      <= rr_d;
            valid_q   <= valid_d;
            hit_q     <= hit_d;
            flt_q     <= flt_d;
            ppn_res_q <= ppn_res_d;
            rwx_res_q <= rwx_res_d;
        end
    end

    // Payload only matters behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (ins_en) begin
            vpn_q[ins_idx]   <= IN_pwResVpn;
            ppn_q[ins_idx]   <= IN_pwResPpn[19:0];
            rwx_q[ins_idx]   <= IN_pwResRwx;
            super_q[ins_idx] <= IN_pwResSuper;
            fault_q[ins_idx] <= IN_pwResFault;
        end
    end

    assign OUT_resHit     = hit_q;
    assign OUT_resFault   = flt_q;
    assign OUT_resPpn     = ppn_res_q;
    assign OUT_resRwx     = rwx_res_q;
    assign OUT_pwReqValid = (state_q == S_REQ);
    assign OUT_pwReqVpn   = req_vpn_q;

endmodule

// File: tb/tb_tlb_multiport.sv
// Directed scenarios then random traffic for tlb_multiport, checked against a
// behavioural TLB model (entry list + walk bookkeeping) kept in the bench.
module tb_tlb_multiport;

    localparam int NUM_RQ = 2;
    localparam int LEN    = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    IN_clear;
    logic [NUM_RQ-1:0]       IN_rqValid;
    logic [NUM_RQ-1:0][19:0] IN_rqVpn;
    logic [NUM_RQ-1:0]       OUT_resHit;
    logic [NUM_RQ-1:0]       OUT_resFault;
    logic [NUM_RQ-1:0][19:0] OUT_resPpn;
    logic [NUM_RQ-1:0][2:0]  OUT_resRwx;
    logic                    OUT_pwReqValid;
    logic [19:0]             OUT_pwReqVpn;
    logic                    IN_pwReady;
    logic                    IN_pwResValid;
    logic [19:0]             IN_pwResVpn;
    logic [21:0]             IN_pwResPpn;
    logic                    IN_pwResSuper;
    logic                    IN_pwResFault;
    logic [2:0]              IN_pwResRwx;

    always #5 clk = ~clk;

    tlb_multiport #(.NUM_RQ(NUM_RQ), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .IN_clear(IN_clear),
        .IN_rqValid(IN_rqValid), .IN_rqVpn(IN_rqVpn),
        .OUT_resHit(OUT_resHit), .OUT_resFault(OUT_resFault),
        .OUT_resPpn(OUT_resPpn), .OUT_resRwx(OUT_resRwx),
        .OUT_pwReqValid(OUT_pwReqValid), .OUT_pwReqVpn(OUT_pwReqVpn),
        .IN_pwReady(IN_pwReady), .IN_pwResValid(IN_pwResValid),
        .IN_pwResVpn(IN_pwResVpn), .IN_pwResPpn(IN_pwResPpn),
        .IN_pwResSuper(IN_pwResSuper), .IN_pwResFault(IN_pwResFault),
        .IN_pwResRwx(IN_pwResRwx)
    );

    typedef struct {
        bit          valid;
        logic [19:0] vpn;
        logic [19:0] ppn;
        bit          sup;
        bit          fault;
        logic [2:0]  rwx;
    } ent_t;

    ent_t        m_tlb [LEN];
    int          m_ptr;
    bit          m_pending, m_waiting, m_drop;
    logic [19:0] m_req_vpn;

    logic [NUM_RQ-1:0]       e_hit, e_fault;
    logic [NUM_RQ-1:0][19:0] e_ppn;
    logic [NUM_RQ-1:0][2:0]  e_rwx;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string name);
        for (int p = 0; p < NUM_RQ; p++) begin
            chk($sformatf("%s hit%0d", name, p),   32'(OUT_resHit[p]),   32'(e_hit[p]));
            chk($sformatf("%s fault%0d", name, p), 32'(OUT_resFault[p]), 32'(e_fault[p]));
            chk($sformatf("%s ppn%0d", name, p),   32'(OUT_resPpn[p]),   32'(e_ppn[p]));
            chk($sformatf("%s rwx%0d", name, p),   32'(OUT_resRwx[p]),   32'(e_rwx[p]));
        end
        chk($sformatf("%s reqValid", name), 32'(OUT_pwReqValid), 32'(m_pending));
        chk($sformatf("%s reqVpn", name),   32'(OUT_pwReqVpn),   32'(m_req_vpn));
    endtask

    task automatic idle_inputs();
        IN_clear = 1'b0; IN_rqValid = '0; IN_rqVpn = '0; IN_pwReady = 1'b0;
        IN_pwResValid = 1'b0; IN_pwResVpn = '0; IN_pwResPpn = '0;
        IN_pwResSuper = 1'b0; IN_pwResFault = 1'b0; IN_pwResRwx = '0;
    endtask

    task automatic set_lookup(input int p, input logic [19:0] v);
        IN_rqValid[p] = 1'b1;
        IN_rqVpn[p]   = v;
    endtask

    task automatic set_result(input logic [19:0] v, input logic [21:0] ppn,
                              input bit sup, input bit fault, input logic [2:0] rwx);
        IN_pwResValid = 1'b1; IN_pwResVpn = v; IN_pwResPpn = ppn;
        IN_pwResSuper = sup;  IN_pwResFault = fault; IN_pwResRwx = rwx;
    endtask

    function automatic int m_find(input logic [19:0] v);
        for (int i = 0; i < LEN; i++)
            if (m_tlb[i].valid && (m_tlb[i].sup ? ((v >> 10) == (m_tlb[i].vpn >> 10)) : (v == m_tlb[i].vpn)))
                return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LEN; i++) m_tlb[i].valid = 1'b0;
        m_ptr = 0; m_pending = 0; m_waiting = 0; m_drop = 0; m_req_vpn = '0;
        e_hit = '0; e_fault = '0; e_ppn = '0; e_rwx = '0;
    endtask

    // Predict the next registered outputs from the current inputs, advance the model, clock, check.
    task automatic step(input string name);
        int          idx, t;
        bit          ins_en, miss_found, idle, n_pend, n_wait, n_drop;
        logic [19:0] miss_vpn, n_req, v;
        e_hit = '0; e_fault = '0; e_ppn = '0; e_rwx = '0;
        idle   = !m_pending && !m_waiting;
        ins_en = IN_pwResValid && !IN_clear && !(m_drop && idle);
        miss_found = 0; miss_vpn = '0;
        for (int p = 0; p < NUM_RQ; p++) begin
            v = IN_rqVpn[p];
            if (IN_rqValid[p] && !IN_clear) begin
                idx = m_find(v);
                if (idx >= 0) begin
                    e_hit[p] = 1'b1;
                    if (m_tlb[idx].fault) e_fault[p] = 1'b1;
                    else begin
                        e_ppn[p] = m_tlb[idx].sup ? ((m_tlb[idx].ppn & 20'hFFC00) | (v & 20'h003FF))
                                                  : m_tlb[idx].ppn;
                        e_rwx[p] = m_tlb[idx].rwx;
                    end
                end else if (!miss_found &&
                             !(ins_en && (IN_pwResSuper ? ((v >> 10) == (IN_pwResVpn >> 10)) : (v == IN_pwResVpn)))) begin
                    miss_found = 1;
                    miss_vpn   = v;
                end
            end
        end
        n_pend = m_pending; n_wait = m_waiting; n_drop = m_drop; n_req = m_req_vpn;
        if (idle && miss_found) begin
            n_pend = 1; n_req = miss_vpn; n_drop = 0;
        end else if (m_pending && IN_pwReady) begin
            n_pend = 0; n_wait = 1;
        end else if (m_waiting && IN_pwResValid && IN_pwResVpn == m_req_vpn) begin
            n_wait = 0;
        end
        if (IN_clear) begin
            n_pend = 0; n_wait = 0; n_drop = 1;
            for (int i = 0; i < LEN; i++) m_tlb[i].valid = 1'b0;
        end else if (ins_en) begin
            t = m_find(IN_pwResVpn);
            if (t < 0)
                for (int i = LEN - 1; i >= 0; i--) if (!m_tlb[i].valid) t = i;
            if (t < 0) begin
                t = m_ptr;
                m_ptr = (m_ptr + 1) % LEN;
            end
            m_tlb[t].valid = 1'b1;            m_tlb[t].vpn = IN_pwResVpn;
            m_tlb[t].ppn   = IN_pwResPpn[19:0]; m_tlb[t].sup = IN_pwResSuper;
            m_tlb[t].fault = IN_pwResFault;   m_tlb[t].rwx = IN_pwResRwx;
        end
        m_pending = n_pend; m_waiting = n_wait; m_drop = n_drop; m_req_vpn = n_req;
        @(posedge clk);
        #1;
        $display("[%0t] %s hit=%b req=%b/%05h", $time, name, OUT_resHit, OUT_pwReqValid, OUT_pwReqVpn);
        check_all(name);
        idle_inputs();
    endtask

    task automatic do_reset(input string name);
        idle_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        $display("[%0t] %s", $time, name);
        check_all(name);
        @(posedge clk);
        #1;
        check_all({name, " held"});
        rst = 1'b1;
    endtask

    initial begin
        idle_inputs();
        do_reset("reset");

        // Basic miss -> walk -> fill -> hit
        set_lookup(0, 20'h12345);                   step("miss 12345");
        IN_pwReady = 1'b1;                          step("walker ready");
        set_result(20'h12345, 22'h0ABCD, 0, 0, 3'b011); step("fill 12345");
        set_lookup(0, 20'h12345);                   step("hit 12345");

        // Superpage
        set_result(20'h40000, 22'h12000, 1, 0, 3'b101); step("fill super 40000");
        set_lookup(1, 20'h40155);                   step("hit super 40155");

        // Fill then round-robin eviction
        do_reset("reset evict");
        for (int i = 0; i < 10; i++) begin
            set_result(20'(i), 22'(20'h100 + i), 0, 0, 3'b111);
            step($sformatf("fill %0d", i));
        end
        set_lookup(0, 20'h0); set_lookup(1, 20'h2); step("evicted 0 / kept 2");
        set_lookup(1, 20'h1);                       step("evicted 1, pending");

        // Two simultaneous misses, miss not queued while busy
        do_reset("reset dual");
        set_lookup(0, 20'h00100); set_lookup(1, 20'h00200); step("dual miss");
        set_lookup(0, 20'h00300);                   step("miss while busy");
        IN_pwReady = 1'b1;                          step("ready 100");
        set_result(20'h00100, 22'h0A100, 0, 0, 3'b001); step("fill 100");
        set_lookup(1, 20'h00200);                   step("reissue 200");
        IN_pwReady = 1'b1;                          step("ready 200");

        // Flush racing an insert and a lookup; stale result dropped
        IN_clear = 1'b1; set_result(20'h00200, 22'h0A200, 0, 0, 3'b010);
        set_lookup(0, 20'h00100);                   step("flush race");
        set_result(20'h00200, 22'h0A200, 0, 0, 3'b010); step("stale result");
        set_lookup(0, 20'h00100); set_lookup(1, 20'h00200); step("after flush");
        IN_pwReady = 1'b1;                          step("ready 100b");
        set_result(20'h00100, 22'h0B100, 0, 0, 3'b100); step("fill 100b");

        // Cached fault
        set_lookup(0, 20'h00777);                   step("miss 777");
        IN_pwReady = 1'b1;                          step("ready 777");
        set_result(20'h00777, 22'h3FFFF, 0, 1, 3'b111); step("fill fault 777");
        set_lookup(0, 20'h00777); set_lookup(1, 20'h00100); step("hit fault 777");

        // Reset mid-walk, late result treated as ordinary insert
        set_lookup(0, 20'h00999);                   step("miss 999");
        IN_pwReady = 1'b1;                          step("ready 999");
        do_reset("reset mid-walk");
        set_result(20'h00999, 22'h05999, 0, 0, 3'b110); step("late fill 999");
        set_lookup(1, 20'h00999);                   step("hit 999");

        // Random traffic over a small vpn pool so hits, supers and evictions collide
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < NUM_RQ; p++)
                if ($urandom_range(0, 1) == 1)
                    set_lookup(p, 20'(($urandom_range(0, 3) << 10) | $urandom_range(0, 5)));
            IN_pwReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                set_result((m_waiting && $urandom_range(0, 1) == 1) ? m_req_vpn
                               : 20'(($urandom_range(0, 3) << 10) | $urandom_range(0, 5)),
                           22'($urandom), $urandom_range(0, 3) == 0,
                           $urandom_range(0, 7) == 0, 3'($urandom));
            IN_clear = ($urandom_range(0, 39) == 0);
            step($sformatf("rand %0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tlb_multiport.md
Name: tlb_multiport

Overview:
Parametrised, fully associative translation lookaside buffer serving NUM_RQ independent lookup ports, each with a registered 1-cycle response. Supports Sv32 4 KiB pages and 4 MiB superpages, stores rwx permissions and page-fault results, and uses invalid-first then round-robin replacement. On a miss it raises a single page-walk request toward the page walker and holds it until the walker responds. A flush invalidates all entries (sfence.vma, satp write).

Parameters:
NUM_RQ, 2, number of lookup ports (1..4)
LEN, 8, number of TLB entries (power of two, 4..32)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
IN_clear  in  1  flush all entries
IN_rqValid  in  NUM_RQ  lookup valid per port
IN_rqVpn  in  NUM_RQ x 20  virtual page number per port
OUT_resHit  out  NUM_RQ  entry found (registered)
OUT_resFault  out  NUM_RQ  hit entry is a cached page fault
OUT_resPpn  out  NUM_RQ x 20  physical page number bits [19:0]
OUT_resRwx  out  NUM_RQ x 3  permission bits of hit entry
OUT_pwReqValid  out  1  page-walk request pending
OUT_pwReqVpn  out  20  vpn to walk
IN_pwReady  in  1  walker accepts request this cycle
IN_pwResValid  in  1  walk result valid (one-cycle pulse)
IN_pwResVpn  in  20  walked vpn
IN_pwResPpn  in  22  walked ppn; bits [19:0] stored
IN_pwResSuper  in  1  result is 4 MiB superpage
IN_pwResFault  in  1  walk ended in page fault
IN_pwResRwx  in  3  permissions

Behaviour:
- Reset (rst=0, async): all entries invalid, round-robin pointer 0, every output 0, request FSM IDLE.
- Entry: valid, vpn[19:0], ppn[19:0], super, fault, rwx.
- Match: valid && (super ? vpn[19:10]==rq[19:10] : vpn==rq). At most one match is guaranteed by insert rules; if several match, the lowest index wins.
- Lookup latency: 1 cycle. Request in cycle N produces outputs in N+1. Outputs with rqValid=0 in N are all 0 in N+1.
- Superpage hit: OUT_resPpn = {entry.ppn[19:10], rqVpn[9:0]}. Otherwise it is entry.ppn.
- Fault entry hit: Hit=1, Fault=1, Ppn=0, Rwx=0.
- Insert on IN_pwResValid:
  - If an existing entry matches IN_pwResVpn, overwrite that entry.
  - Otherwise write the lowest invalid entry.
  - If no entry is invalid, write the entry at the round-robin pointer, then increment the pointer mod LEN.
  - The pointer advances only on eviction.
- Same-cycle lookup and insert: the lookup sees pre-insert contents. The entry is visible to lookups starting in the next cycle.
- Flush (IN_clear):
  - All valid bits clear at the edge.
  - Lookups issued in the same cycle as IN_clear return miss (masked).
  - Flush and insert in the same cycle: flush wins, insert is dropped.
  - Flush also returns the request FSM to IDLE.
  - A walk result arriving after a flush while the FSM is IDLE is dropped.
- Request FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ: in the cycle after a valid lookup misses. Latch vpn from the lowest-index missing port.
  - Miss suppression: a miss is ignored if it matches the in-flight vpn, or the IN_pwResVpn being inserted in that cycle.
  - REQ: OUT_pwReqValid=1 and OUT_pwReqVpn are held stable. REQ -> WAIT when IN_pwReady=1.
  - WAIT -> IDLE when IN_pwResValid=1 with IN_pwResVpn equal to the latched vpn. A non-matching result is still inserted, and the FSM stays in WAIT.
  - In REQ or WAIT, further misses are not queued. Requesters re-issue them.
  - IN_clear in any state -> IDLE, OUT_pwReqValid=0 the next cycle.
- Reset asserted mid-walk: FSM returns to IDLE and all entries are invalidated. A late walk result arriving after reset is handled as an ordinary insert.

Test Plan:
- Reset, then port0 lookup vpn 0x12345 -> next cycle Hit=0. Next cycle OUT_pwReqValid=1, OUT_pwReqVpn=0x12345. IN_pwReady=1, then result ppn 0x0ABCD rwx=3'b011 -> subsequent lookup gives Hit=1, Ppn=0x0ABCD, Rwx=3'b011, FSM IDLE.
- Insert superpage vpn 0x40000, ppn 0x12000, Super=1, then lookup vpn 0x40155 on port1 -> Hit=1, Ppn=0x12155.
- Fill LEN=8 entries with vpn 0..7, then insert vpn 8 -> entry 0 (vpn 0) evicted, pointer=1. Insert vpn 9 -> vpn 1 evicted. Lookup vpn 0 -> miss, vpn 2 -> hit.
- Two ports miss in the same cycle (vpn 0x100 on port0, 0x200 on port1) -> only 0x100 is requested. Re-issued 0x200 after fill -> new request 0x200.
- IN_clear in the same cycle as an IN_pwResValid insert and a lookup of a cached vpn -> lookup misses, insert dropped, all later lookups miss, OUT_pwReqValid=0.
- Faulting walk result (Fault=1) for vpn 0x00777 -> lookup returns Hit=1, Fault=1, Ppn=0, Rwx=0, and no new page-walk request is issued.
